// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 2-of-3 majority vote per bit, optional odd/even parity.
// Each byte is presented with a one-cycle o_valid strobe plus framing and parity flags.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int PARITY   = 0
) (
  input  logic       irs_clk_50M,
  input  logic       irs_reset_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy,
  output logic [2:0] o_state
);

  localparam int OVS_DIV = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W   = $clog2(OVS_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVS_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PAR     = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic             rx_s1, rx_s2, rx_s3;
  logic             fall;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [3:0]       bit_cnt;
  logic             tick, at_mid, at_end;
  logic             s7, s8, bit_val;
  logic [7:0]       shreg;
  logic             p_err;
  logic             counting;

  // Two synchronizer flops; the third only serves falling-edge detection.
  always_ff @(posedge irs_clk_50M or negedge irs_reset_n) begin
    if (!irs_reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign fall     = rx_s3 & ~rx_s2;
  assign counting = (state == START) || (state == DATA) || (state == PAR) || (state == STOP);
  assign tick     = counting && (div_cnt == DIV_LAST);
  assign at_mid   = tick && (tick_cnt == 4'd9);
  assign at_end   = tick && (tick_cnt == 4'd15);
  // Third vote is the live synchronized line at tick 9.
  assign bit_val  = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);

  always_ff @(posedge irs_clk_50M or negedge irs_reset_n) begin
    if (!irs_reset_n) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fall) state_nxt = START;
      START:   if (at_mid && bit_val) state_nxt = IDLE;
               else if (at_end)      state_nxt = DATA;
      DATA:    if (at_end && bit_cnt == 4'd8) state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:     if (at_end) state_nxt = STOP;
      STOP:    if (at_mid) state_nxt = bit_val ? IDLE : WAIT_HI;
      WAIT_HI: if (rx_s2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (state != IDLE);
    o_state = state;
  end

  always_ff @(posedge irs_clk_50M or negedge irs_reset_n) begin
    if (!irs_reset_n) begin
      div_cnt      <= '0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      s7           <= 1'b1;
      s8           <= 1'b1;
      shreg        <= '0;
      p_err        <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!counting) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        p_err    <= 1'b0;
      end else begin
        if (tick) begin
          div_cnt  <= '0;
          tick_cnt <= tick_cnt + 4'd1;
        end else begin
          div_cnt  <= div_cnt + 1'b1;
        end
        if (tick && tick_cnt == 4'd7) s7 <= rx_s2;
        if (tick && tick_cnt == 4'd8) s8 <= rx_s2;
        if (at_mid) begin
          case (state)
            DATA: begin
              shreg   <= {bit_val, shreg[7:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
            PAR:  p_err <= ((^shreg) ^ bit_val) != (PARITY == 1);
            STOP: begin
              o_data       <= shreg;
              o_valid      <= 1'b1;
              o_frame_err  <= ~bit_val;
              o_parity_err <= p_err;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
